// File: rtl/timing_sequencer.sv
// timing_sequencer: sequence counter, run/interrupt flags and opcode decode
// strobes for the basic computer's per-register control logic.
module timing_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] IR,
    input  logic        FGI,
    input  logic        FGO,
    output logic [7:0]  T,
    output logic [7:0]  D,
    output logic        I,
    output logic        R,
    output logic        IEN,
    output logic        S,
    output logic [15:0] B,
    output logic        SC_CLR
);
    logic [2:0] sc;
    logic       p;
    logic       r;
    logic       fetch_t2;
    logic       irq_req;
    logic       ien_clr;

    always_comb begin
        T        = S ? (8'b1 << sc) : 8'h00;
        B        = {4'h0, IR[11:0]};
        p        = D[7] & I & T[3];
        r        = D[7] & ~I & T[3];
        fetch_t2 = ~R & T[2];
        // T0..T2 are masked so a request never lands mid-fetch or on the clearing edge
        irq_req  = S & ~T[0] & ~T[1] & ~T[2] & IEN & (FGI | FGO);
        ien_clr  = (p & B[6]) | (R & T[2]);
        SC_CLR   = S & ((R & T[2]) | (~R & ((D[0] & T[5]) | (D[1] & T[5]) | (D[2] & T[5])
                 | (D[3] & T[4]) | (D[4] & T[4]) | (D[5] & T[5]) | (D[6] & T[6])
                 | (D[7] & T[3]))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc  <= 3'd0;
            S   <= 1'b0;
            R   <= 1'b0;
            IEN <= 1'b0;
            I   <= 1'b0;
            D   <= 8'h00;
        end else if (!S) begin
            S <= start;
        end else begin
            sc  <= SC_CLR ? 3'd0 : sc + 3'd1;
            D   <= fetch_t2 ? (8'b1 << IR[14:12]) : D;
            I   <= fetch_t2 ? IR[15] : I;
            R   <= (R & T[2]) ? 1'b0 : (irq_req ? 1'b1 : R);
            IEN <= ien_clr ? 1'b0 : ((p & B[7]) ? 1'b1 : IEN);
            S   <= ~(r & B[0]);
        end
    end
endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer: cycle-by-cycle vector table checked through a scoreboard queue.
module tb_timing_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic        FGI = 1'b0;
    logic        FGO = 1'b0;
    logic [7:0]  T;
    logic [7:0]  D;
    logic        I;
    logic        R;
    logic        IEN;
    logic        S;
    logic [15:0] B;
    logic        SC_CLR;

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] ir;
        logic        fgi;
        logic        fgo;
        logic [7:0]  t;
        logic [7:0]  d;
        logic        i;
        logic        r;
        logic        ien;
        logic        s;
        logic        clr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    timing_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .IR(IR), .FGI(FGI), .FGO(FGO),
        .T(T), .D(D), .I(I), .R(R), .IEN(IEN), .S(S), .B(B), .SC_CLR(SC_CLR)
    );

    always #5 clk = ~clk;

    task automatic v(input logic rs, input logic st, input logic [15:0] ir,
                     input logic fi, input logic fo, input logic [7:0] t,
                     input logic [7:0] d, input logic i, input logic r,
                     input logic ien, input logic s, input logic clr);
        vec_t x;
        x.rst = rs; x.start = st; x.ir = ir; x.fgi = fi; x.fgo = fo;
        x.t = t; x.d = d; x.i = i; x.r = r; x.ien = ien; x.s = s; x.clr = clr;
        vecs.push_back(x);
    endtask

    task automatic chk(input int n, input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h expected %h", n, name, act, exp);
        end
    endtask

    initial begin
        // power-on reset, then a plain LDA instruction
        v(0,1,16'h0000,0,0,8'h00,8'h00,0,0,0,0,0);
        v(0,0,16'h0000,0,0,8'h01,8'h00,0,0,0,1,0);
        v(0,0,16'h2005,0,0,8'h02,8'h00,0,0,0,1,0);
        v(0,0,16'h2005,0,0,8'h04,8'h00,0,0,0,1,0);
        v(0,0,16'h2005,0,0,8'h08,8'h04,0,0,0,1,0);
        v(0,0,16'h2005,0,0,8'h10,8'h04,0,0,0,1,0);
        v(0,0,16'h2005,0,0,8'h20,8'h04,0,0,0,1,1);
        // HLT, five idle cycles, restart
        v(0,0,16'h7001,0,0,8'h01,8'h04,0,0,0,1,0);
        v(0,0,16'h7001,0,0,8'h02,8'h04,0,0,0,1,0);
        v(0,0,16'h7001,0,0,8'h04,8'h04,0,0,0,1,0);
        v(0,0,16'h7001,0,0,8'h08,8'h80,0,0,0,1,1);
        for (int k = 0; k < 5; k++) v(0,0,16'h7001,0,0,8'h00,8'h80,0,0,0,0,0);
        v(0,1,16'h7001,0,0,8'h00,8'h80,0,0,0,0,0);
        // ION
        v(0,0,16'hF080,0,0,8'h01,8'h80,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h02,8'h80,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h04,8'h80,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h08,8'h80,1,0,0,1,1);
        // LDA with FGI at T3 -> R sets, counter runs on through wrap into RT0..RT2
        v(0,0,16'h2005,0,0,8'h01,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,0,0,8'h02,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,0,0,8'h04,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,1,0,8'h08,8'h04,0,0,1,1,0);
        v(0,0,16'h2005,0,0,8'h10,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h20,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h40,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h80,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h01,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h02,8'h04,0,1,1,1,0);
        v(0,0,16'h2005,0,0,8'h04,8'h04,0,1,1,1,1);
        // ION again, then FGO during T0..T3: R only after T3
        v(0,0,16'hF080,0,0,8'h01,8'h04,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h02,8'h04,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h04,8'h04,0,0,0,1,0);
        v(0,0,16'hF080,0,0,8'h08,8'h80,1,0,0,1,1);
        v(0,0,16'h2005,0,1,8'h01,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,0,1,8'h02,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,0,1,8'h04,8'h80,1,0,1,1,0);
        v(0,0,16'h2005,0,1,8'h08,8'h04,0,0,1,1,0);
        v(0,0,16'h2005,0,0,8'h10,8'h04,0,1,1,1,0);
        v(1,0,16'h2005,0,0,8'h20,8'h04,0,1,1,1,0);
        // ISZ interrupted by reset at T4
        v(0,1,16'h6000,0,0,8'h00,8'h00,0,0,0,0,0);
        v(0,0,16'h6000,0,0,8'h01,8'h00,0,0,0,1,0);
        v(0,0,16'h6000,0,0,8'h02,8'h00,0,0,0,1,0);
        v(0,0,16'h6000,0,0,8'h04,8'h00,0,0,0,1,0);
        v(0,0,16'h6000,0,0,8'h08,8'h40,0,0,0,1,0);
        v(1,0,16'h6000,0,0,8'h10,8'h40,0,0,0,1,0);
        // AND (D0) ends at T5; start while running is ignored
        v(0,1,16'h0000,0,0,8'h00,8'h00,0,0,0,0,0);
        v(0,0,16'h0000,0,0,8'h01,8'h00,0,0,0,1,0);
        v(0,0,16'h0000,0,0,8'h02,8'h00,0,0,0,1,0);
        v(0,0,16'h0000,0,0,8'h04,8'h00,0,0,0,1,0);
        v(0,0,16'h0ABC,0,0,8'h08,8'h01,0,0,0,1,0);
        v(0,1,16'h0ABC,0,0,8'h10,8'h01,0,0,0,1,0);
        v(0,0,16'h0ABC,0,0,8'h20,8'h01,0,0,0,1,1);
        v(0,0,16'h0ABC,0,0,8'h01,8'h01,0,0,0,1,0);
        @(posedge clk);
        for (int n = 0; n < vecs.size(); n++) begin
            vec_t e;
            @(negedge clk);
            rst = vecs[n].rst; start = vecs[n].start; IR = vecs[n].ir;
            FGI = vecs[n].fgi; FGO = vecs[n].fgo;
            sb.push_back(vecs[n]);
            #1;
            e = sb.pop_front();
            chk(n, "T", {8'h00, T}, {8'h00, e.t});
            chk(n, "D", {8'h00, D}, {8'h00, e.d});
            chk(n, "I", {15'h0, I}, {15'h0, e.i});
            chk(n, "R", {15'h0, R}, {15'h0, e.r});
            chk(n, "IEN", {15'h0, IEN}, {15'h0, e.ien});
            chk(n, "S", {15'h0, S}, {15'h0, e.s});
            chk(n, "SC_CLR", {15'h0, SC_CLR}, {15'h0, e.clr});
            chk(n, "B", B, {4'h0, e.ir[11:0]});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
